delay_pipe: RTL and testbench
=============================

DELAY_PIPE -- requirements
Module: delay_pipe

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of register stages; legal range 0..64.
REQ-002 SHALL have parameter DATA, default 64, meaning the width of one lane in bits.
REQ-003 SHALL have parameter LANES, default 1, meaning the number of data lanes sharing one valid/enable.
REQ-004 SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port en_i, input, 1 bit: advance enable; 0 stalls the whole pipe.
REQ-007 SHALL have port flush_i, input, 1 bit: drops all in-flight valid tokens.
REQ-008 SHALL have port valid_i, input, 1 bit: input token valid.
REQ-009 SHALL have port data_i, input, LANES*DATA bits: input payload, lane n in bits [n*DATA +: DATA].
REQ-010 SHALL have port valid_o, output, 1 bit: output token valid.
REQ-011 SHALL have port data_o, output, LANES*DATA bits: delayed payload.
REQ-012 SHALL have port inflight_o, output, $clog2(DEPTH+1) bits (minimum 1): count of valid tokens held in the pipe.
REQ-013 SHALL have port empty_o, output, 1 bit: high when inflight_o == 0.

Function
REQ-014 On a rising edge with en_i=1, stage 0 SHALL load data_i/valid_i and stage k+1 SHALL load stage k, for k=0..DEPTH-2.
REQ-015 On a rising edge with en_i=0, all stages SHALL hold data and valid unchanged.
REQ-016 data_o/valid_o SHALL be driven directly (no extra register) from stage DEPTH-1.
REQ-017 Latency SHALL be exactly DEPTH enabled edges; stalled cycles SHALL add no latency and SHALL neither drop nor duplicate a token.
REQ-018 flush_i=1 on an edge SHALL clear every valid bit, including the token accepted on that edge, regardless of en_i.
REQ-019 Data registers SHALL follow en_i even when flush_i=1; payload of invalid stages is don't-care to consumers but SHALL be deterministic.
REQ-020 inflight_o SHALL be a registered counter, updated per edge:
  - flush: 0
  - else en_i=1: +valid_i, -valid bit of stage DEPTH-1
  - else: hold.
REQ-021 inflight_o SHALL always equal the popcount of stage valid bits; it SHALL never wrap (maximum DEPTH, minimum 0).
REQ-022 Simultaneous token entry and exit with en_i=1 SHALL leave inflight_o unchanged.
REQ-023 DEPTH=0 SHALL be a combinational pass-through: data_o=data_i, valid_o=valid_i, inflight_o=0, empty_o=1; en_i and flush_i ignored.
REQ-024 All lanes SHALL move in lockstep; no cross-lane mixing.

Reset
REQ-025 rst_ni=0 SHALL immediately, without a clock edge, clear all valid bits, all data registers to 0 and inflight_o to 0, so valid_o=0, data_o=0, empty_o=1 (DEPTH>0).
REQ-026 Reset asserted mid-operation SHALL discard all in-flight tokens; the first enabled edge after deassertion SHALL behave as from an empty pipe.
REQ-027 Reset SHALL take priority over flush_i and en_i.

Structure
REQ-028 No typedefs are needed; the default constants (DATA default 64, DEPTH maximum 64) SHALL live in shared package delay_pkg.
REQ-029 One stage SHALL be sub-module delay_stage: an enable-gated, async-reset register of valid plus LANES*DATA bits, instantiated DEPTH times in a generate loop.
REQ-030 Counter width SHALL derive from DEPTH inside delay_pipe; no width hard-coding.

Verification
REQ-031 Scenario 1: DEPTH=4, en_i=1, valid_i high for one cycle with data 0xA5 -> valid_o high with 0xA5 exactly 4 edges later, inflight_o goes 1 then 0.
REQ-032 Scenario 2: DEPTH=4, inject tokens 1,2,3, then drop en_i for 3 cycles -> outputs frozen; 1,2,3 emerge in order on subsequent enabled edges with no gaps added.
REQ-033 Scenario 3: fill DEPTH=4 with 4 tokens (inflight_o=4), assert flush_i with valid_i=1 -> next cycle inflight_o=0, valid_o=0 for the following 4 enabled edges.
REQ-034 Scenario 4: LANES=3, DATA=8, data_i=0x33_22_11 -> data_o=0x33_22_11 after DEPTH edges, lanes unswapped.
REQ-035 Scenario 5: pull rst_ni low between edges with 2 tokens in flight -> valid_o, data_o, inflight_o zero immediately; no token emerges afterwards.
REQ-036 Scenario 6: DEPTH=0, toggle valid_i/data_i -> outputs follow in the same cycle; inflight_o stays 0, empty_o stays 1.

Source files
------------

// File: rtl/delay_pkg.sv
// Shared defaults for the delay pipeline: lane width default and depth ceiling.
package delay_pkg;

    localparam int DATA_DEFAULT = 64;
    localparam int DEPTH_MAX    = 64;

endpackage

// File: rtl/delay_stage.sv
// One pipeline stage: enable-gated valid + payload register with flush on the valid bit.
module delay_stage #(
    parameter int WIDTH = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             flush_i,
    input  logic             valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its upstream neighbour's pre-edge value and the chain shifts by one.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_o <= 1'b0;
            // NOTE: payload is reset too, so invalid stages read as a known 0
            // rather than X; the cost is one reset net per data flop.
            data_o  <= '0;
        end else begin
            if (flush_i) begin
                valid_o <= 1'b0;
            end else if (en_i) begin
                valid_o <= valid_i;
            end
            if (en_i) begin
                data_o <= data_i;
            end
        end
    end

endmodule

// File: rtl/delay_pipe.sv
// Fixed-latency valid/data delay line with stall, flush and an in-flight token counter.
module delay_pipe
    import delay_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DATA  = DATA_DEFAULT,
    parameter int LANES = 1,
    localparam int CNT_W = (DEPTH > 0) ? $clog2(DEPTH + 1) : 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   en_i,
    input  logic                   flush_i,
    input  logic                   valid_i,
    input  logic [LANES*DATA-1:0]  data_i,
    output logic                   valid_o,
    output logic [LANES*DATA-1:0]  data_o,
    output logic [CNT_W-1:0]       inflight_o,
    output logic                   empty_o
);

    localparam int WIDTH = LANES * DATA;

    if (DEPTH == 0) begin : g_pass
        assign valid_o    = valid_i;
        assign data_o     = data_i;
        assign inflight_o = '0;
        assign empty_o    = 1'b1;

        logic unused_ok;
        assign unused_ok = ^{clk_i, rst_ni, en_i, flush_i};
    end else begin : g_pipe
        // Index 0 is the pipe input; index k+1 is the output of stage k.
        logic [DEPTH:0] valid_s;
        logic [WIDTH-1:0] data_s [DEPTH+1];
        logic [CNT_W-1:0] count;

        assign valid_s[0] = valid_i;
        assign data_s[0]  = data_i;

        for (genvar k = 0; k < DEPTH; k++) begin : g_stage
            delay_stage #(.WIDTH(WIDTH)) u_stage (
                .clk_i   (clk_i),
                .rst_ni  (rst_ni),
                .en_i    (en_i),
                .flush_i (flush_i),
                .valid_i (valid_s[k]),
                .data_i  (data_s[k]),
                .valid_o (valid_s[k+1]),
                .data_o  (data_s[k+1])
            );
        end

        // Tracks the popcount of stage valid bits incrementally: one token may
        // enter and one may leave per enabled edge, so the count never wraps.
        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                count <= '0;
            end else if (flush_i) begin
                count <= '0;
            end else if (en_i) begin
                case ({valid_i, valid_s[DEPTH]})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end

        assign valid_o    = valid_s[DEPTH];
        assign data_o     = data_s[DEPTH];
        assign inflight_o = count;
        assign empty_o    = (count == '0);
    end

endmodule

// File: tb/tb_delay_pipe.sv
// Scoreboard bench for delay_pipe: DEPTH=4 main instance, 3-lane instance and DEPTH=0 pass-through.
module tb_delay_pipe;

    localparam int D = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        en, flush, vin, vout, emp;
    logic [63:0] din, dout;
    logic [2:0]  infl;

    logic        l_en, l_flush, l_vin, l_vout, l_emp;
    logic [23:0] l_din, l_dout;
    logic [2:0]  l_infl;

    logic        p_en, p_flush, p_vin, p_vout, p_emp;
    logic [15:0] p_din, p_dout;
    logic [0:0]  p_infl;

    delay_pipe #(.DEPTH(D), .DATA(64), .LANES(1)) u_dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .flush_i(flush), .valid_i(vin),
        .data_i(din), .valid_o(vout), .data_o(dout), .inflight_o(infl), .empty_o(emp)
    );

    delay_pipe #(.DEPTH(D), .DATA(8), .LANES(3)) u_lanes (
        .clk_i(clk), .rst_ni(rst_n), .en_i(l_en), .flush_i(l_flush), .valid_i(l_vin),
        .data_i(l_din), .valid_o(l_vout), .data_o(l_dout), .inflight_o(l_infl), .empty_o(l_emp)
    );

    delay_pipe #(.DEPTH(0), .DATA(16), .LANES(1)) u_pass (
        .clk_i(clk), .rst_ni(rst_n), .en_i(p_en), .flush_i(p_flush), .valid_i(p_vin),
        .data_i(p_din), .valid_o(p_vout), .data_o(p_dout), .inflight_o(p_infl), .empty_o(p_emp)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          tag;
        logic [63:0] data;
    } tok_t;

    tok_t sb[$];
    int   en_cnt = 0;

    // A token entering on enabled edge n sits at the output after enabled edge n+D-1.
    function automatic bit exp_valid();
        return (sb.size() > 0) && (sb[0].tag + D - 1 == en_cnt);
    endfunction

    function automatic logic [63:0] exp_data();
        return (sb.size() > 0) ? sb[0].data : 64'h0;
    endfunction

    task automatic tick(input logic v, input logic [63:0] d, input logic e, input logic f);
        vin = v; din = d; en = e; flush = f;
        @(posedge clk);
        #1;
        if (e) begin
            if (exp_valid()) void'(sb.pop_front());
            en_cnt++;
            if (v) sb.push_back('{tag: en_cnt, data: d});
        end
        if (f) sb.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++;
        if (vout !== 1'b0 || dout !== 64'h0 || infl !== 3'd0 || emp !== 1'b1) begin
            errors++;
            $display("FAIL reset_state: valid_o=%0b data_o=%h inflight_o=%0d empty_o=%0b, expected 0/0/0/1",
                     vout, dout, infl, emp);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        for (int k = 1; k <= 5; k++) begin
            tick(k == 1, 64'hA5, 1'b1, 1'b0);
            checks++;
            if (vout !== (k == 4) || (k == 4 && dout !== 64'hA5)) begin
                errors++;
                $display("FAIL single_latency edge %0d: valid_o=%0b data_o=%h, expected valid=%0b data=a5",
                         k, vout, dout, (k == 4));
            end
            checks++;
            if (infl !== 3'((k <= 4) ? 1 : 0)) begin
                errors++;
                $display("FAIL single_inflight edge %0d: inflight_o=%0d, expected %0d",
                         k, infl, (k <= 4) ? 1 : 0);
            end
        end
    endtask

    task automatic test_stall();
        for (int i = 1; i <= 3; i++) tick(1'b1, 64'(i), 1'b1, 1'b0);
        for (int s = 0; s < 3; s++) begin
            tick(1'b1, 64'hDEAD, 1'b0, 1'b0);
            checks++;
            if (vout !== 1'b0 || infl !== 3'd3) begin
                errors++;
                $display("FAIL stall_frozen cycle %0d: valid_o=%0b inflight_o=%0d, expected 0 and 3",
                         s, vout, infl);
            end
        end
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 64'h0, 1'b1, 1'b0);
            checks++;
            if (vout !== (i < 3) || (i < 3 && dout !== 64'(i + 1))) begin
                errors++;
                $display("FAIL stall_drain edge %0d: valid_o=%0b data_o=%h, expected valid=%0b data=%0d",
                         i, vout, dout, (i < 3), i + 1);
            end
            checks++;
            if (vout !== exp_valid() || (exp_valid() && dout !== exp_data()) || infl !== 3'(sb.size())) begin
                errors++;
                $display("FAIL stall_sb edge %0d: valid_o=%0b data_o=%h inflight_o=%0d, expected %0b %h %0d",
                         i, vout, dout, infl, exp_valid(), exp_data(), sb.size());
            end
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 4; i++) tick(1'b1, 64'h100 + 64'(i), 1'b1, 1'b0);
        checks++;
        if (infl !== 3'd4 || vout !== 1'b1 || dout !== 64'h100) begin
            errors++;
            $display("FAIL flush_full: inflight_o=%0d valid_o=%0b data_o=%h, expected 4 1 100", infl, vout, dout);
        end
        tick(1'b1, 64'h999, 1'b1, 1'b1);
        checks++;
        if (infl !== 3'd0 || vout !== 1'b0 || emp !== 1'b1) begin
            errors++;
            $display("FAIL flush_clear: inflight_o=%0d valid_o=%0b empty_o=%0b, expected 0 0 1", infl, vout, emp);
        end
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 64'h0, 1'b1, 1'b0);
            checks++;
            if (vout !== 1'b0 || infl !== 3'd0) begin
                errors++;
                $display("FAIL flush_after edge %0d: valid_o=%0b inflight_o=%0d, expected 0 0", i, vout, infl);
            end
        end
        tick(1'b1, 64'h77, 1'b1, 1'b0);
        tick(1'b0, 64'h0, 1'b0, 1'b1);
        checks++;
        if (infl !== 3'd0 || emp !== 1'b1) begin
            errors++;
            $display("FAIL flush_stalled: inflight_o=%0d empty_o=%0b, expected 0 1", infl, emp);
        end
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 64'h0, 1'b1, 1'b0);
            checks++;
            if (vout !== 1'b0) begin
                errors++;
                $display("FAIL flush_stalled_after edge %0d: valid_o=%0b, expected 0", i, vout);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 300; i++) begin
            logic v, e, f;
            v = (i < 20) ? 1'b1 : 1'($urandom_range(0, 1));
            e = (i < 20) ? 1'b1 : ($urandom_range(0, 3) != 0);
            f = (i < 20) ? 1'b0 : ($urandom_range(0, 31) == 0);
            tick(v, {$urandom, $urandom}, e, f);
            checks++;
            if (vout !== exp_valid() || (exp_valid() && dout !== exp_data())
                || infl !== 3'(sb.size()) || emp !== (sb.size() == 0)) begin
                errors++;
                $display("FAIL stream cycle %0d: valid_o=%0b data_o=%h inflight_o=%0d empty_o=%0b, expected %0b %h %0d %0b",
                         i, vout, dout, infl, emp, exp_valid(), exp_data(), sb.size(), (sb.size() == 0));
            end
        end
        while (sb.size() > 0 && en_cnt < 100000) tick(1'b0, 64'h0, 1'b1, 1'b0);
    endtask

    task automatic test_lanes();
        l_en = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            l_vin = (k <= 2);
            l_din = (k == 1) ? 24'h332211 : (k == 2) ? 24'hABCDEF : 24'hFFFFFF;
            @(posedge clk);
            #1;
            checks++;
            if (l_vout !== (k == 4 || k == 5)
                || (k == 4 && l_dout !== 24'h332211) || (k == 5 && l_dout !== 24'hABCDEF)) begin
                errors++;
                $display("FAIL lanes edge %0d: valid_o=%0b data_o=%h, expected valid=%0b data=%h",
                         k, l_vout, l_dout, (k == 4 || k == 5), (k == 4) ? 24'h332211 : 24'hABCDEF);
            end
        end
        l_vin = 1'b0;
    endtask

    task automatic test_reset_mid();
        tick(1'b1, 64'h11, 1'b1, 1'b0);
        tick(1'b1, 64'h22, 1'b1, 1'b0);
        checks++;
        if (infl !== 3'd2) begin
            errors++;
            $display("FAIL reset_mid_pre: inflight_o=%0d, expected 2", infl);
        end
        #2;
        rst_n = 1'b0;
        #1;
        sb.delete();
        checks++;
        if (vout !== 1'b0 || dout !== 64'h0 || infl !== 3'd0 || emp !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_async: valid_o=%0b data_o=%h inflight_o=%0d empty_o=%0b, expected 0/0/0/1",
                     vout, dout, infl, emp);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(i == 5, 64'h33, 1'b1, 1'b0);
            checks++;
            if (vout !== (i == 8) || (i == 8 && dout !== 64'h33) || infl !== 3'(sb.size())) begin
                errors++;
                $display("FAIL reset_mid_after edge %0d: valid_o=%0b data_o=%h inflight_o=%0d, expected %0b 33 %0d",
                         i, vout, dout, infl, (i == 8), sb.size());
            end
        end
    endtask

    task automatic test_passthru();
        for (int i = 0; i < 8; i++) begin
            logic [2:0]  sel;
            logic [15:0] val;
            sel     = 3'(i);
            val     = 16'($urandom);
            p_vin   = sel[0];
            p_en    = sel[1];
            p_flush = sel[2];
            p_din   = val;
            #3;
            checks++;
            if (p_vout !== sel[0] || p_dout !== val || p_infl !== 1'b0 || p_emp !== 1'b1) begin
                errors++;
                $display("FAIL passthru step %0d: valid_o=%0b data_o=%h inflight_o=%0d empty_o=%0b, expected %0b %h 0 1",
                         i, p_vout, p_dout, p_infl, p_emp, sel[0], val);
            end
        end
    endtask

    initial begin
        en = 1'b0; flush = 1'b0; vin = 1'b0; din = '0;
        l_en = 1'b0; l_flush = 1'b0; l_vin = 1'b0; l_din = '0;
        p_en = 1'b0; p_flush = 1'b0; p_vin = 1'b0; p_din = '0;
        test_reset();
        test_single();
        test_stall();
        test_flush();
        test_back_to_back();
        test_lanes();
        test_reset_mid();
        test_passthru();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
